// File: rtl/decode.sv
// ID-stage instruction decoder for the MIPS pipeline: turns an instruction word
// into registered datapath controls and an ALU operation code.
module decode (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instruction,
   output logic        MemtoReg,
   output logic        RegWrite,
   output logic        MemWrite,
   output logic        MemRead,
   output logic [4:0]  ALUCode,
   output logic        ALUSrcA,
   output logic        ALUSrcB,
   output logic        RegDst,
   output logic        J,
   output logic        JR
);

   logic [5:0] op;
   logic [4:0] rt;
   logic [5:0] funct;

   logic       mem_to_reg, reg_write, mem_write, mem_read;
   logic [4:0] alu_code;
   logic       src_a, src_b, reg_dst, jump, jump_reg;

   assign op    = Instruction[31:26];
   assign rt    = Instruction[20:16];
   assign funct = Instruction[5:0];

   // Anything not matched below (jal, unknown op/funct) leaves every control at 0.
   always_comb begin
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      mem_read   = 1'b0;
      alu_code   = 5'd0;
      src_a      = 1'b0;
      src_b      = 1'b0;
      reg_dst    = 1'b0;
      jump       = 1'b0;
      jump_reg   = 1'b0;

      case (op)
         6'h00: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            case (funct)
               6'h20, 6'h21: alu_code = 5'd0;
               6'h22, 6'h23: alu_code = 5'd5;
               6'h24:        alu_code = 5'd1;
               6'h25:        alu_code = 5'd3;
               6'h26:        alu_code = 5'd2;
               6'h27:        alu_code = 5'd4;
               6'h2A:        alu_code = 5'd19;
               6'h2B:        alu_code = 5'd20;
               6'h00: begin alu_code = 5'd16; src_a = 1'b1; end
               6'h02: begin alu_code = 5'd17; src_a = 1'b1; end
               6'h03: begin alu_code = 5'd18; src_a = 1'b1; end
               6'h08: begin
                  alu_code  = 5'd9;
                  jump_reg  = 1'b1;
                  reg_write = 1'b0;
                  reg_dst   = 1'b0;
               end
               default: begin
                  reg_write = 1'b0;
                  reg_dst   = 1'b0;
               end
            endcase
         end
         6'h08, 6'h09: begin reg_write = 1'b1; src_b = 1'b1; alu_code = 5'd0;  end
         6'h0A:        begin reg_write = 1'b1; src_b = 1'b1; alu_code = 5'd19; end
         6'h0B:        begin reg_write = 1'b1; src_b = 1'b1; alu_code = 5'd20; end
         6'h0C:        begin reg_write = 1'b1; src_b = 1'b1; alu_code = 5'd6;  end
         6'h0D:        begin reg_write = 1'b1; src_b = 1'b1; alu_code = 5'd8;  end
         6'h0E:        begin reg_write = 1'b1; src_b = 1'b1; alu_code = 5'd7;  end
         6'h23: begin
            mem_read   = 1'b1;
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            src_b      = 1'b1;
         end
         6'h2B: begin
            mem_write = 1'b1;
            src_b     = 1'b1;
         end
         6'h04: alu_code = 5'd10;
         6'h05: alu_code = 5'd11;
         6'h06: alu_code = 5'd14;
         6'h07: alu_code = 5'd13;
         // REGIMM: only rt 0 (bltz) and rt 1 (bgez) are supported.
         6'h01: begin
            if (rt == 5'd1)
               alu_code = 5'd12;
            else if (rt == 5'd0)
               alu_code = 5'd15;
         end
         6'h02: jump = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         MemtoReg <= 1'b0;
         RegWrite <= 1'b0;
         MemWrite <= 1'b0;
         MemRead  <= 1'b0;
         ALUCode  <= 5'd0;
         ALUSrcA  <= 1'b0;
         ALUSrcB  <= 1'b0;
         RegDst   <= 1'b0;
         J        <= 1'b0;
         JR       <= 1'b0;
      end else begin
         MemtoReg <= mem_to_reg;
         RegWrite <= reg_write;
         MemWrite <= mem_write;
         MemRead  <= mem_read;
         ALUCode  <= alu_code;
         ALUSrcA  <= src_a;
         ALUSrcB  <= src_b;
         RegDst   <= reg_dst;
         J        <= jump;
         JR       <= jump_reg;
      end
   end

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: each step queues its expected control word and
// checks it against the registered outputs one edge later.
module tb_decode;

   logic        clk;
   logic        reset;
   logic [31:0] Instruction;
   logic        MemtoReg, RegWrite, MemWrite, MemRead;
   logic [4:0]  ALUCode;
   logic        ALUSrcA, ALUSrcB, RegDst, J, JR;

   typedef struct {
      string       tag;
      logic [13:0] ctl;
   } expect_t;

   expect_t expQ[$];
   int      compared   = 0;
   int      mismatched = 0;

   decode dut (
      .clk         (clk),
      .reset       (reset),
      .Instruction (Instruction),
      .MemtoReg    (MemtoReg),
      .RegWrite    (RegWrite),
      .MemWrite    (MemWrite),
      .MemRead     (MemRead),
      .ALUCode     (ALUCode),
      .ALUSrcA     (ALUSrcA),
      .ALUSrcB     (ALUSrcB),
      .RegDst      (RegDst),
      .J           (J),
      .JR          (JR)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control word layout: {MemtoReg,RegWrite,MemWrite,MemRead,ALUCode,ALUSrcA,ALUSrcB,RegDst,J,JR}
   function automatic logic [13:0] ctl(input logic mtr, input logic rw, input logic mw,
                                       input logic mr, input logic [4:0] code,
                                       input logic sa, input logic sb, input logic rd,
                                       input logic j, input logic jr);
      return {mtr, rw, mw, mr, code, sa, sb, rd, j, jr};
   endfunction

   task automatic checkOutput();
      expect_t     e;
      logic [13:0] obs;
      obs = {MemtoReg, RegWrite, MemWrite, MemRead, ALUCode, ALUSrcA, ALUSrcB, RegDst, J, JR};
      compared++;
      if (expQ.size() == 0) begin
         mismatched++;
         $display("[TB] FAIL scoreboard_empty: observed %b required an expected entry", obs);
         return;
      end
      e = expQ.pop_front();
      assert (obs === e.ctl) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %b expected %b", e.tag, obs, e.ctl);
      end
   endtask

   task automatic applyStimulus(input string tag, input logic rst,
                                input logic [31:0] instr, input logic [13:0] expected);
      expect_t e;
      @(negedge clk);
      reset       = rst;
      Instruction = instr;
      e.tag = tag;
      e.ctl = expected;
      expQ.push_back(e);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      reset       = 1'b1;
      Instruction = 32'h0;

      applyStimulus("reset0", 1'b1, 32'h8d2c0008, ctl(0,0,0,0,5'd0,0,0,0,0,0));
      applyStimulus("reset1", 1'b1, 32'h0800000b, ctl(0,0,0,0,5'd0,0,0,0,0,0));
      applyStimulus("j",      1'b0, 32'h0800000b, ctl(0,0,0,0,5'd0,0,0,0,1,0));
      applyStimulus("addi",   1'b0, 32'h20080042, ctl(0,1,0,0,5'd0,0,1,0,0,0));
      applyStimulus("sub",    1'b0, 32'h01095022, ctl(0,1,0,0,5'd5,0,0,1,0,0));
      applyStimulus("or",     1'b0, 32'h01485825, ctl(0,1,0,0,5'd3,0,0,1,0,0));
      applyStimulus("sw",     1'b0, 32'hac0b000c, ctl(0,0,1,0,5'd0,0,1,0,0,0));
      applyStimulus("lw",     1'b0, 32'h8d2c0008, ctl(1,1,0,1,5'd0,0,1,0,0,0));
      applyStimulus("sll",    1'b0, 32'h000c4080, ctl(0,1,0,0,5'd16,1,0,1,0,0));
      applyStimulus("sltu",   1'b0, 32'h012a582b, ctl(0,1,0,0,5'd20,0,0,1,0,0));
      applyStimulus("bne",    1'b0, 32'h14000001, ctl(0,0,0,0,5'd11,0,0,0,0,0));
      applyStimulus("beq",    1'b0, 32'h1000fff4, ctl(0,0,0,0,5'd10,0,0,0,0,0));
      applyStimulus("jr",     1'b0, 32'h03e00008, ctl(0,0,0,0,5'd9,0,0,0,0,1));
      applyStimulus("rst_sub",1'b1, 32'h01095022, ctl(0,0,0,0,5'd0,0,0,0,0,0));
      applyStimulus("post_or",1'b0, 32'h01485825, ctl(0,1,0,0,5'd3,0,0,1,0,0));

      applyStimulus("nop",    1'b0, 32'h00000000, ctl(0,1,0,0,5'd16,1,0,1,0,0));
      applyStimulus("srl",    1'b0, 32'h00000002, ctl(0,1,0,0,5'd17,1,0,1,0,0));
      applyStimulus("sra",    1'b0, 32'h00000003, ctl(0,1,0,0,5'd18,1,0,1,0,0));
      applyStimulus("and",    1'b0, 32'h00000024, ctl(0,1,0,0,5'd1,0,0,1,0,0));
      applyStimulus("xor",    1'b0, 32'h00000026, ctl(0,1,0,0,5'd2,0,0,1,0,0));
      applyStimulus("nor",    1'b0, 32'h00000027, ctl(0,1,0,0,5'd4,0,0,1,0,0));
      applyStimulus("addu",   1'b0, 32'h00000021, ctl(0,1,0,0,5'd0,0,0,1,0,0));
      applyStimulus("subu",   1'b0, 32'h00000023, ctl(0,1,0,0,5'd5,0,0,1,0,0));
      applyStimulus("slt",    1'b0, 32'h0000002a, ctl(0,1,0,0,5'd19,0,0,1,0,0));
      applyStimulus("bad_fn", 1'b0, 32'h00000001, ctl(0,0,0,0,5'd0,0,0,0,0,0));
      applyStimulus("addiu",  1'b0, 32'h24000005, ctl(0,1,0,0,5'd0,0,1,0,0,0));
      applyStimulus("slti",   1'b0, 32'h28000000, ctl(0,1,0,0,5'd19,0,1,0,0,0));
      applyStimulus("sltiu",  1'b0, 32'h2c000000, ctl(0,1,0,0,5'd20,0,1,0,0,0));
      applyStimulus("andi",   1'b0, 32'h30000000, ctl(0,1,0,0,5'd6,0,1,0,0,0));
      applyStimulus("ori",    1'b0, 32'h3408ffff, ctl(0,1,0,0,5'd8,0,1,0,0,0));
      applyStimulus("xori",   1'b0, 32'h38000000, ctl(0,1,0,0,5'd7,0,1,0,0,0));
      applyStimulus("blez",   1'b0, 32'h18000000, ctl(0,0,0,0,5'd14,0,0,0,0,0));
      applyStimulus("bgtz",   1'b0, 32'h1c000000, ctl(0,0,0,0,5'd13,0,0,0,0,0));
      applyStimulus("bgez",   1'b0, 32'h04010003, ctl(0,0,0,0,5'd12,0,0,0,0,0));
      applyStimulus("bltz",   1'b0, 32'h04000003, ctl(0,0,0,0,5'd15,0,0,0,0,0));
      applyStimulus("regimm2",1'b0, 32'h04020003, ctl(0,0,0,0,5'd0,0,0,0,0,0));
      applyStimulus("jal",    1'b0, 32'h0c000000, ctl(0,0,0,0,5'd0,0,0,0,0,0));
      applyStimulus("bad_op", 1'b0, 32'hfc000000, ctl(0,0,0,0,5'd0,0,0,0,0,0));

      compared++;
      assert (expQ.size() == 0) else begin
         mismatched++;
         $error("[TB] FAIL scoreboard_drain: observed %0d left expected 0", expQ.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/decode.md
Name: decode

Overview:
- Instruction decoder for the ID stage of the MIPS pipeline CPU.
- Turns a 32-bit MIPS instruction word into the datapath control signals and a 5-bit ALU operation code.
- Outputs are registered: one clock of latency, feeding the ID/EX control path.

Parameters:
- None.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all outputs.
- Instruction  input  32  instruction word in the ID stage.
- MemtoReg  output  1  write-back data comes from memory (lw).
- RegWrite  output  1  register file write enable.
- MemWrite  output  1  data memory write (sw).
- MemRead  output  1  data memory read (lw).
- ALUCode  output  5  ALU operation select.
- ALUSrcA  output  1  ALU A operand is shamt (Instruction[10:6]) instead of rs.
- ALUSrcB  output  1  ALU B operand is the immediate instead of rt.
- RegDst  output  1  destination is rd (1) or rt (0).
- J  output  1  jump (j).
- JR  output  1  jump register (jr).

Behaviour:
- Field split: op = [31:26], rt = [20:16], funct = [5:0].
- Decode is combinational. Every output is registered on the rising edge of clk, so an instruction applied before edge N is reflected after edge N.
- reset=1 at an edge: all outputs go to 0 (ALUCode = 0). Reset has priority over any instruction.
- ALUCode encoding: add 0, and 1, xor 2, or 3, nor 4, sub 5, andi 6, xori 7, ori 8, jr 9, beq 10, bne 11, bgez 12, bgtz 13, blez 14, bltz 15, sll 16, srl 17, sra 18, slt 19, sltu 20.
- R-type (op = 0x00), decoded by funct:
  - add/addu: code 0. sub/subu: code 5.
  - and 1, or 3, xor 2, nor 4, slt 19, sltu 20.
  - sll 16, srl 17, sra 18.
  - jr: code 9.
- Controls for R-type:
  - All R-type except jr: RegWrite = 1, RegDst = 1.
  - Shifts (sll/srl/sra) additionally: ALUSrcA = 1.
  - jr: JR = 1, RegWrite = 0.
  - The all-zero word (nop = sll $0,$0,0) decodes as sll with RegWrite = 1. It is harmless because rd = $0.
- I-type arithmetic/logic: RegWrite = 1, ALUSrcB = 1, RegDst = 0.
  - addi 0x08 / addiu 0x09: code 0.
  - slti 0x0A: code 19. sltiu 0x0B: code 20.
  - andi 0x0C: code 6. ori 0x0D: code 8. xori 0x0E: code 7.
- Memory:
  - lw 0x23: MemRead = 1, MemtoReg = 1, RegWrite = 1, ALUSrcB = 1, code 0.
  - sw 0x2B: MemWrite = 1, ALUSrcB = 1, code 0, RegWrite = 0.
- Branches: no writes, ALUSrcA/ALUSrcB = 0.
  - beq 0x04: code 10. bne 0x05: code 11.
  - blez 0x06: code 14. bgtz 0x07: code 13.
  - op 0x01 with rt = 1: bgez, code 12. With rt = 0: bltz, code 15.
- Jump: j 0x02: J = 1, all other controls 0, code 0.
- Unsupported op/funct (including jal): all outputs 0.
- At most one of J/JR is 1. MemRead and MemWrite are never both 1.

Test Plan:
- reset=1 for 2 cycles with any Instruction -> all outputs 0. Then Instruction=0x0800000b (j), reset=0 -> after next edge J=1, JR=0, RegWrite=0, ALUCode=0.
- 0x20080042 (addi) -> RegWrite=1, ALUSrcB=1, RegDst=0, ALUCode=0. Then 0x01095022 (sub) -> RegWrite=1, RegDst=1, ALUSrcB=0, ALUCode=5. Then 0x01485825 (or) -> ALUCode=3, RegDst=1.
- 0xac0b000c (sw) -> MemWrite=1, ALUSrcB=1, RegWrite=0, MemRead=0, ALUCode=0. Then 0x8d2c0008 (lw) -> MemRead=1, MemtoReg=1, RegWrite=1, ALUSrcB=1, RegDst=0.
- 0x000c4080 (sll) -> ALUSrcA=1, RegDst=1, RegWrite=1, ALUCode=16. Then 0x012a582b (sltu) -> ALUCode=20, ALUSrcA=0.
- 0x14000001 (bne) -> ALUCode=11, no write/mem flags. Then 0x1000fff4 (beq) -> ALUCode=10. Then 0x03e00008 (jr) -> JR=1, ALUCode=9, RegWrite=0.
- Assert reset during sub decode -> outputs 0 after that edge. Release reset -> the next instruction decodes normally one cycle later.
